// File: rtl/pong_collision_engine_if.sv
// Bus bundle between the Pong position registers / ball_fsm and the collision engine.
// Master drives frame-qualified ball and paddle geometry; slave (the engine) returns events and match status.
// Widths follow the engine's POS_W / SIZE_W / SCORE_W parameters.
interface pong_collision_engine_if #(
   parameter int POS_W   = 10,
   parameter int SIZE_W  = 8,
   parameter int SCORE_W = 4
);
   logic               i_frame_tick;
   logic               i_start;
   logic               i_ball_dir_x;
   logic               i_ball_dir_y;
   logic [POS_W-1:0]   i_ball_pos_x;
   logic [POS_W-1:0]   i_ball_pos_y;
   logic [SIZE_W-1:0]  i_ball_size_x;
   logic [SIZE_W-1:0]  i_ball_size_y;
   logic [POS_W-1:0]   i_paddle_1_pos_x;
   logic [POS_W-1:0]   i_paddle_1_pos_y;
   logic [SIZE_W-1:0]  i_paddle_1_size_x;
   logic [SIZE_W-1:0]  i_paddle_1_size_y;
   logic [POS_W-1:0]   i_paddle_2_pos_x;
   logic [POS_W-1:0]   i_paddle_2_pos_y;
   logic [SIZE_W-1:0]  i_paddle_2_size_x;
   logic [SIZE_W-1:0]  i_paddle_2_size_y;

   logic               o_event_valid;
   logic [2:0]         o_event_code;
   logic [1:0]         o_hit_zone;
   logic [SCORE_W-1:0] o_score_player_1;
   logic [SCORE_W-1:0] o_score_player_2;
   logic               o_playing;
   logic               o_game_over;
   logic               o_winner;

   modport master (
      output i_frame_tick, i_start, i_ball_dir_x, i_ball_dir_y,
      output i_ball_pos_x, i_ball_pos_y, i_ball_size_x, i_ball_size_y,
      output i_paddle_1_pos_x, i_paddle_1_pos_y, i_paddle_1_size_x, i_paddle_1_size_y,
      output i_paddle_2_pos_x, i_paddle_2_pos_y, i_paddle_2_size_x, i_paddle_2_size_y,
      input  o_event_valid, o_event_code, o_hit_zone,
      input  o_score_player_1, o_score_player_2, o_playing, o_game_over, o_winner
   );

   modport slave (
      input  i_frame_tick, i_start, i_ball_dir_x, i_ball_dir_y,
      input  i_ball_pos_x, i_ball_pos_y, i_ball_size_x, i_ball_size_y,
      input  i_paddle_1_pos_x, i_paddle_1_pos_y, i_paddle_1_size_x, i_paddle_1_size_y,
      input  i_paddle_2_pos_x, i_paddle_2_pos_y, i_paddle_2_size_x, i_paddle_2_size_y,
      output o_event_valid, o_event_code, o_hit_zone,
      output o_score_player_1, o_score_player_2, o_playing, o_game_over, o_winner
   );
endinterface

// File: rtl/pong_collision_engine.sv
// Frame-qualified collision / scoring / match-control engine; one event pulse per frame_tick at most.
// Latency: event and status registered, visible 1 cycle after the frame_tick; no backpressure (events are fire-and-forget).
// Optional paddle hit-zone output enabled by defining COLLISION_HIT_ZONE_EN; otherwise o_hit_zone is tied to 0.
module pong_collision_engine #(
   parameter int POS_W        = 10,
   parameter int SIZE_W       = 8,
   parameter int SCREEN_X     = 640,
   parameter int SCREEN_Y     = 480,
   parameter int MARGIN       = 5,
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 11,
   parameter int SERVE_FRAMES = 60
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   pong_collision_engine_if.slave io_bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_OVER} state_t;

   localparam logic [2:0] EV_NONE  = 3'd0;
   localparam logic [2:0] EV_PAD1  = 3'd1;
   localparam logic [2:0] EV_PAD2  = 3'd2;
   localparam logic [2:0] EV_WALL  = 3'd3;
   localparam logic [2:0] EV_GOALL = 3'd4;
   localparam logic [2:0] EV_GOALR = 3'd5;
   localparam logic [2:0] EV_SERVE = 3'd6;

   // Sums are one bit wider than positions so pos+size never wraps.
   localparam int SUM_W = POS_W + 1;
   localparam logic [SUM_W-1:0] GOAL_R_X = SUM_W'(SCREEN_X - MARGIN);
   localparam logic [SUM_W-1:0] WALL_B_Y = SUM_W'(SCREEN_Y - MARGIN);
   localparam logic [POS_W-1:0] MARG     = POS_W'(MARGIN);

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'((SERVE_FRAMES > 0) ? SERVE_FRAMES - 1 : 0);
   localparam logic [SCORE_W-1:0] WIN_SC = SCORE_W'(WIN_SCORE);

   state_t             r_state,     w_state_nxt;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
   logic [SCORE_W-1:0] r_score_1,   w_score_1_nxt;
   logic [SCORE_W-1:0] r_score_2,   w_score_2_nxt;
   logic               r_winner,    w_winner_nxt;
   logic               r_ev_vld,    w_ev_vld_nxt;
   logic [2:0]         r_ev_code,   w_ev_code_nxt;
   logic [1:0]         r_zone,      w_zone_nxt;
   logic               r_playing;
   logic               r_game_over;

   // Geometry: extended edges of ball and paddles.
   logic [SUM_W-1:0] w_ball_r, w_ball_b, w_p1_r, w_p1_b, w_p2_b;
   logic             w_goal_r, w_goal_l, w_wall, w_hit_p1, w_hit_p2;
   logic [SCORE_W-1:0] w_score_1_inc, w_score_2_inc;
   logic             w_serve_done;
   logic [1:0]       w_zone_p1, w_zone_p2;

   assign w_ball_r = SUM_W'(io_bus.i_ball_pos_x)     + SUM_W'(io_bus.i_ball_size_x);
   assign w_ball_b = SUM_W'(io_bus.i_ball_pos_y)     + SUM_W'(io_bus.i_ball_size_y);
   assign w_p1_r   = SUM_W'(io_bus.i_paddle_1_pos_x) + SUM_W'(io_bus.i_paddle_1_size_x);
   assign w_p1_b   = SUM_W'(io_bus.i_paddle_1_pos_y) + SUM_W'(io_bus.i_paddle_1_size_y);
   assign w_p2_b   = SUM_W'(io_bus.i_paddle_2_pos_y) + SUM_W'(io_bus.i_paddle_2_size_y);

   assign w_goal_r = (w_ball_r >= GOAL_R_X);
   assign w_goal_l = (io_bus.i_ball_pos_x <= MARG);
   // Walls only fire when the ball heads into them, so a bounced ball cannot re-trigger.
   assign w_wall   = ((io_bus.i_ball_pos_y <= MARG) &&  io_bus.i_ball_dir_y) ||
                     ((w_ball_b >= WALL_B_Y)        && !io_bus.i_ball_dir_y);
   assign w_hit_p1 = io_bus.i_ball_dir_x &&
                     (SUM_W'(io_bus.i_ball_pos_x) <= w_p1_r) &&
                     (w_ball_b >= SUM_W'(io_bus.i_paddle_1_pos_y)) &&
                     (SUM_W'(io_bus.i_ball_pos_y) <= w_p1_b);
   assign w_hit_p2 = !io_bus.i_ball_dir_x &&
                     (w_ball_r >= SUM_W'(io_bus.i_paddle_2_pos_x)) &&
                     (w_ball_b >= SUM_W'(io_bus.i_paddle_2_pos_y)) &&
                     (SUM_W'(io_bus.i_ball_pos_y) <= w_p2_b);

   assign w_score_1_inc = r_score_1 + SCORE_W'(1);
   assign w_score_2_inc = r_score_2 + SCORE_W'(1);
   assign w_serve_done  = (SERVE_FRAMES == 0) || (r_cnt == SERVE_LAST);

`ifdef COLLISION_HIT_ZONE_EN
   // Quarter of the paddle struck by the ball's vertical centre; above the paddle top clamps to zone 0.
   function automatic logic [1:0] f_zone(input logic [POS_W-1:0]  by,
                                         input logic [SIZE_W-1:0] bh,
                                         input logic [POS_W-1:0]  py,
                                         input logic [SIZE_W-1:0] ph);
      logic [POS_W+1:0]  ctr;
      logic [POS_W+1:0]  off;
      logic [SIZE_W+1:0] three_ph;
      logic [POS_W+1:0]  q1, q2, q3;
      ctr      = (POS_W+2)'(by) + (POS_W+2)'(bh >> 1);
      off      = (ctr > (POS_W+2)'(py)) ? (ctr - (POS_W+2)'(py)) : '0;
      three_ph = {2'b00, ph} + {1'b0, ph, 1'b0};
      q1       = (POS_W+2)'(ph >> 2);
      q2       = (POS_W+2)'(ph >> 1);
      q3       = (POS_W+2)'(three_ph >> 2);
      if (off < q1)      f_zone = 2'd0;
      else if (off < q2) f_zone = 2'd1;
      else if (off < q3) f_zone = 2'd2;
      else               f_zone = 2'd3;
   endfunction

   assign w_zone_p1 = f_zone(io_bus.i_ball_pos_y, io_bus.i_ball_size_y,
                             io_bus.i_paddle_1_pos_y, io_bus.i_paddle_1_size_y);
   assign w_zone_p2 = f_zone(io_bus.i_ball_pos_y, io_bus.i_ball_size_y,
                             io_bus.i_paddle_2_pos_y, io_bus.i_paddle_2_size_y);
`else
   assign w_zone_p1 = 2'd0;
   assign w_zone_p2 = 2'd0;
`endif

   // Next-state, score and event decode; first matching rule wins on each PLAY frame.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_score_1_nxt = r_score_1;
      w_score_2_nxt = r_score_2;
      w_winner_nxt  = r_winner;
      w_ev_vld_nxt  = 1'b0;
      w_ev_code_nxt = EV_NONE;
      w_zone_nxt    = 2'd0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.i_start) begin
               w_state_nxt = ST_SERVE;
               w_cnt_nxt   = '0;
            end
         end
         ST_SERVE: begin
            if (io_bus.i_frame_tick) begin
               if (w_serve_done) begin
                  w_ev_vld_nxt  = 1'b1;
                  w_ev_code_nxt = EV_SERVE;
                  w_state_nxt   = ST_PLAY;
                  w_cnt_nxt     = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_PLAY: begin
            if (io_bus.i_frame_tick) begin
               if (w_goal_r) begin
                  w_ev_vld_nxt  = 1'b1;
                  w_ev_code_nxt = EV_GOALR;
                  w_score_1_nxt = w_score_1_inc;
                  w_cnt_nxt     = '0;
                  if (w_score_1_inc == WIN_SC) begin
                     w_state_nxt  = ST_OVER;
                     w_winner_nxt = 1'b0;
                  end else begin
                     w_state_nxt = ST_SERVE;
                  end
               end else if (w_goal_l) begin
                  w_ev_vld_nxt  = 1'b1;
                  w_ev_code_nxt = EV_GOALL;
                  w_score_2_nxt = w_score_2_inc;
                  w_cnt_nxt     = '0;
                  if (w_score_2_inc == WIN_SC) begin
                     w_state_nxt  = ST_OVER;
                     w_winner_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_SERVE;
                  end
               end else if (w_wall) begin
                  w_ev_vld_nxt  = 1'b1;
                  w_ev_code_nxt = EV_WALL;
               end else if (w_hit_p1) begin
                  w_ev_vld_nxt  = 1'b1;
                  w_ev_code_nxt = EV_PAD1;
                  w_zone_nxt    = w_zone_p1;
               end else if (w_hit_p2) begin
                  w_ev_vld_nxt  = 1'b1;
                  w_ev_code_nxt = EV_PAD2;
                  w_zone_nxt    = w_zone_p2;
               end
            end
         end
         ST_OVER: begin
            if (io_bus.i_start) begin
               w_score_1_nxt = '0;
               w_score_2_nxt = '0;
               w_state_nxt   = ST_SERVE;
               w_cnt_nxt     = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers; reset wins over every other input.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_score_1   <= '0;
         r_score_2   <= '0;
         r_winner    <= 1'b0;
         r_ev_vld    <= 1'b0;
         r_ev_code   <= EV_NONE;
         r_zone      <= 2'd0;
         r_playing   <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_score_1   <= w_score_1_nxt;
         r_score_2   <= w_score_2_nxt;
         r_winner    <= w_winner_nxt;
         r_ev_vld    <= w_ev_vld_nxt;
         r_ev_code   <= w_ev_code_nxt;
         r_zone      <= w_zone_nxt;
         r_playing   <= (w_state_nxt == ST_PLAY);
         r_game_over <= (w_state_nxt == ST_OVER);
      end
   end

   assign io_bus.o_event_valid    = r_ev_vld;
   assign io_bus.o_event_code     = r_ev_code;
   assign io_bus.o_hit_zone       = r_zone;
   assign io_bus.o_score_player_1 = r_score_1;
   assign io_bus.o_score_player_2 = r_score_2;
   assign io_bus.o_playing        = r_playing;
   assign io_bus.o_game_over      = r_game_over;
   assign io_bus.o_winner         = r_winner;

endmodule

// File: tb/tb_pong_collision_engine.sv
// Directed bench for pong_collision_engine (SERVE_FRAMES=3, WIN_SCORE=2).
// Expected events are queued when a frame_tick is driven and compared one cycle later.
// Hit-zone expectations follow COLLISION_HIT_ZONE_EN when defined.
module tb_pong_collision_engine;
   localparam int POS_W   = 10;
   localparam int SIZE_W  = 8;
   localparam int SCORE_W = 4;

`ifdef COLLISION_HIT_ZONE_EN
   localparam logic [1:0] Z_P1 = 2'd2;
   localparam logic [1:0] Z_P2 = 2'd1;
`else
   localparam logic [1:0] Z_P1 = 2'd0;
   localparam logic [1:0] Z_P2 = 2'd0;
`endif

   typedef struct packed {
      logic       vld;
      logic [2:0] code;
      logic [1:0] zone;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pong_collision_engine_if #(.POS_W(POS_W), .SIZE_W(SIZE_W), .SCORE_W(SCORE_W)) bus ();

   pong_collision_engine #(
      .POS_W(POS_W), .SIZE_W(SIZE_W), .SCORE_W(SCORE_W),
      .SERVE_FRAMES(3), .WIN_SCORE(2)
   ) dut (
      .i_clock  (clk),
      .i_reset_n(rst_n),
      .io_bus   (bus)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ball(input logic [9:0] x, input logic [9:0] y, input logic dx, input logic dy);
      bus.i_ball_pos_x = x;
      bus.i_ball_pos_y = y;
      bus.i_ball_dir_x = dx;
      bus.i_ball_dir_y = dy;
   endtask

   // Called at a negedge: pulse frame_tick, then compare the registered event one cycle later.
   task automatic tick(input string tag, input logic [2:0] code, input logic [1:0] zone);
      exp_t e;
      e.vld  = (code != 3'd0);
      e.code = code;
      e.zone = (code == 3'd1 || code == 3'd2) ? zone : 2'd0;
      sb.push_back(e);
      bus.i_frame_tick = 1'b1;
      @(negedge clk);
      bus.i_frame_tick = 1'b0;
      e = sb.pop_front();
      check({tag, ".vld"},  16'(bus.o_event_valid), 16'(e.vld));
      check({tag, ".code"}, 16'(bus.o_event_code),  16'(e.code));
      check({tag, ".zone"}, 16'(bus.o_hit_zone),    16'(e.zone));
      @(negedge clk);
      check({tag, ".single"}, 16'(bus.o_event_valid), 16'd0);
   endtask

   task automatic serve(input string tag);
      tick({tag, ".s1"}, 3'd0, 2'd0);
      tick({tag, ".s2"}, 3'd0, 2'd0);
      tick({tag, ".s3"}, 3'd6, 2'd0);
      check({tag, ".playing"}, 16'(bus.o_playing), 16'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".vld"},  16'(bus.o_event_valid),    16'd0);
      check({tag, ".code"}, 16'(bus.o_event_code),     16'd0);
      check({tag, ".zone"}, 16'(bus.o_hit_zone),       16'd0);
      check({tag, ".s1"},   16'(bus.o_score_player_1), 16'd0);
      check({tag, ".s2"},   16'(bus.o_score_player_2), 16'd0);
      check({tag, ".play"}, 16'(bus.o_playing),        16'd0);
      check({tag, ".over"}, 16'(bus.o_game_over),      16'd0);
      check({tag, ".win"},  16'(bus.o_winner),         16'd0);
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_frame_tick = 1'b0;
      bus.i_start      = 1'b0;
      set_ball(10'd300, 10'd200, 1'b1, 1'b0);
      bus.i_ball_size_x     = 8'd8;
      bus.i_ball_size_y     = 8'd8;
      bus.i_paddle_1_pos_x  = 10'd10;
      bus.i_paddle_1_pos_y  = 10'd100;
      bus.i_paddle_1_size_x = 8'd8;
      bus.i_paddle_1_size_y = 8'd40;
      bus.i_paddle_2_pos_x  = 10'd620;
      bus.i_paddle_2_pos_y  = 10'd200;
      bus.i_paddle_2_size_x = 8'd8;
      bus.i_paddle_2_size_y = 8'd40;

      // Power-on reset
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // IDLE ignores ticks; start with a same-cycle tick does not count as a serve frame
      tick("idle", 3'd0, 2'd0);
      bus.i_frame_tick = 1'b1;
      pulse_start();
      bus.i_frame_tick = 1'b0;
      check("start.vld",  16'(bus.o_event_valid), 16'd0);
      check("start.play", 16'(bus.o_playing),     16'd0);
      serve("serve1");

      // Play-field events
      tick("mid", 3'd0, 2'd0);
      set_ball(10'd300, 10'd4, 1'b1, 1'b1);
      tick("wall_up", 3'd3, 2'd0);
      set_ball(10'd300, 10'd4, 1'b1, 1'b0);
      tick("wall_away", 3'd0, 2'd0);
      set_ball(10'd17, 10'd118, 1'b1, 1'b0);
      tick("pad1", 3'd1, Z_P1);
      set_ball(10'd17, 10'd118, 1'b0, 1'b0);
      tick("pad1_away", 3'd0, 2'd0);
      set_ball(10'd613, 10'd210, 1'b0, 1'b0);
      tick("pad2", 3'd2, Z_P2);

      // Left goal beats a simultaneous top-wall hit
      set_ball(10'd3, 10'd4, 1'b1, 1'b1);
      tick("goal_l", 3'd4, 2'd0);
      check("goal_l.s2",   16'(bus.o_score_player_2), 16'd1);
      check("goal_l.s1",   16'(bus.o_score_player_1), 16'd0);
      check("goal_l.play", 16'(bus.o_playing),        16'd0);
      set_ball(10'd300, 10'd200, 1'b1, 1'b0);
      serve("serve2");

      // Reset in the middle of play, frame_tick asserted meanwhile
      rst_n = 1'b0;
      bus.i_frame_tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("midreset");
      rst_n = 1'b1;
      bus.i_frame_tick = 1'b0;
      tick("post_reset", 3'd0, 2'd0);

      // Player 1 wins with two right goals
      pulse_start();
      serve("serve3");
      set_ball(10'd630, 10'd200, 1'b0, 1'b0);
      tick("goal_r1", 3'd5, 2'd0);
      check("goal_r1.s1",   16'(bus.o_score_player_1), 16'd1);
      check("goal_r1.over", 16'(bus.o_game_over),      16'd0);
      set_ball(10'd300, 10'd200, 1'b0, 1'b0);
      pulse_start();
      serve("serve4");
      set_ball(10'd630, 10'd200, 1'b0, 1'b0);
      tick("goal_r2", 3'd5, 2'd0);
      check("win1.s1",   16'(bus.o_score_player_1), 16'd2);
      check("win1.over", 16'(bus.o_game_over),      16'd1);
      check("win1.who",  16'(bus.o_winner),         16'd0);
      check("win1.play", 16'(bus.o_playing),        16'd0);
      tick("over_frozen", 3'd0, 2'd0);
      check("over_frozen.s1", 16'(bus.o_score_player_1), 16'd2);

      // Restart clears scores; then player 2 wins with two left goals
      pulse_start();
      check("restart.s1",   16'(bus.o_score_player_1), 16'd0);
      check("restart.over", 16'(bus.o_game_over),      16'd0);
      set_ball(10'd300, 10'd200, 1'b1, 1'b0);
      serve("serve5");
      set_ball(10'd5, 10'd200, 1'b1, 1'b0);
      tick("goal_l1", 3'd4, 2'd0);
      check("goal_l1.s2", 16'(bus.o_score_player_2), 16'd1);
      set_ball(10'd300, 10'd200, 1'b1, 1'b0);
      serve("serve6");
      set_ball(10'd5, 10'd200, 1'b1, 1'b0);
      tick("goal_l2", 3'd4, 2'd0);
      check("win2.s2",   16'(bus.o_score_player_2), 16'd2);
      check("win2.over", 16'(bus.o_game_over),      16'd1);
      check("win2.who",  16'(bus.o_winner),         16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
